// File: rtl/comparator_if.sv
// Candidate/target operand bundle and registered compare result for the
// 256-bit hash comparator.
interface comparator_if;
    logic [255:0] hashOut;
    logic [255:0] target;
    logic         out;
    logic [255:0] outHash;

    modport master (
        output hashOut,
        output target,
        input  out,
        input  outHash
    );

    modport slave (
        input  hashOut,
        input  target,
        output out,
        output outHash
    );
endinterface

// File: rtl/comparator.sv
// Two-stage pipelined 256-bit unsigned "hashOut <= target" compare.
// Stage 1 registers per-64-bit-slice flags; stage 2 resolves them MSB first.
module comparator (
    input  logic        clk,
    input  logic        reset,
    comparator_if.slave cmp
);
    logic [3:0]   lt_s1;
    logic [3:0]   eq_s1;
    logic [255:0] hash_s1;
    logic         pass;
    logic         out_r;
    logic [255:0] outhash_r;

    for (genvar s = 0; s < 4; s++) begin : g_slice
        always_ff @(posedge clk) begin
            if (reset) begin
                lt_s1[s] <= 1'b0;
                eq_s1[s] <= 1'b0;
            end else begin
                lt_s1[s] <= cmp.hashOut[s*64 +: 64] <  cmp.target[s*64 +: 64];
                eq_s1[s] <= cmp.hashOut[s*64 +: 64] == cmp.target[s*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hash_s1 <= '0;
        end else begin
            hash_s1 <= cmp.hashOut;
        end
    end

    // The highest unequal slice decides; all-equal passes. Cleared flags
    // (lt=0, eq=0) resolve to fail, so a flushed stage 1 never passes.
    always_comb begin
        pass = lt_s1[3] | (eq_s1[3] &
               (lt_s1[2] | (eq_s1[2] &
               (lt_s1[1] | (eq_s1[1] &
               (lt_s1[0] | eq_s1[0]))))));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_r     <= 1'b0;
            outhash_r <= '0;
        end else begin
            out_r     <= pass;
            outhash_r <= pass ? hash_s1 : '0;
        end
    end

    assign cmp.out     = out_r;
    assign cmp.outHash = outhash_r;
endmodule

// File: tb/tb_comparator.sv
// Directed and randomized check of comparator against a "<=" reference model
// with a two-clock result lag and reset flushing.
module tb_comparator;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    comparator_if cmp ();

    comparator dut (
        .clk   (clk),
        .reset (rst),
        .cmp   (cmp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: the operand pair applied one edge earlier and whether
    // it survived (no reset at that edge).
    logic [255:0] prev_h;
    logic [255:0] prev_t;
    logic         prev_valid;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic step(input logic [255:0] h, input logic [255:0] t,
                        input logic r, input string tag);
        logic         exp_out;
        logic [255:0] exp_hash;
        @(negedge clk);
        cmp.hashOut = h;
        cmp.target  = t;
        rst         = r;
        @(posedge clk);
        #1;
        if (r || !prev_valid) begin
            exp_out  = 1'b0;
            exp_hash = '0;
        end else begin
            exp_out  = (prev_h <= prev_t);
            exp_hash = exp_out ? prev_h : 256'h0;
        end
        checks++;
        assert (cmp.out === exp_out) else begin
            errors++;
            $error("FAIL %s out observed=%b expected=%b", tag, cmp.out, exp_out);
        end
        checks++;
        assert (cmp.outHash === exp_hash) else begin
            errors++;
            $error("FAIL %s outHash observed=%h expected=%h", tag, cmp.outHash, exp_hash);
        end
        prev_h     = h;
        prev_t     = t;
        prev_valid = !r;
    endtask

    initial begin
        logic [255:0] h;
        logic [255:0] t;
        logic [255:0] one;
        logic         r;
        int unsigned  mode;
        int unsigned  k;
        checks     = 0;
        errors     = 0;
        prev_h     = '0;
        prev_t     = '0;
        prev_valid = 1'b0;
        one        = 256'h1;
        cmp.hashOut = '0;
        cmp.target  = '0;
        rst         = 1'b1;

        // Reset state, including a passing input presented during reset.
        step(256'h0, 256'h0, 1'b1, "reset0");
        step(256'h3, 256'h7, 1'b1, "reset1");

        // Directed sequence against target 0x7.
        step(256'hF,  256'h7, 1'b0, "f_vs_7");
        step(256'h1F, 256'h7, 1'b0, "1f_vs_7");
        step(256'h3,  256'h7, 1'b0, "3_vs_7");
        step(256'hF,  256'h7, 1'b0, "f_vs_7b");
        step(256'hF,  256'h7, 1'b0, "drain0");

        // Equality and MSB-slice boundaries.
        step(256'hDEADBEEF << 128, 256'hDEADBEEF << 128, 1'b0, "eq_mid");
        step(one << 255, (one << 255) - 1, 1'b0, "msb_fail");
        step((one << 255) - 1, one << 255, 1'b0, "msb_pass");
        step('1, '1, 1'b0, "all_ones");
        step(256'h0, rnd256(), 1'b0, "zero_hash");
        step(rnd256() | one, 256'h0, 1'b0, "zero_target");
        h = rnd256();
        step(h | one, h & ~one, 1'b0, "bit0_fail");
        step(h & ~one, h | one, 1'b0, "bit0_pass");
        step(h | (one << 255), h & ~(one << 255), 1'b0, "bit255_fail");

        // Constant inputs give constant outputs.
        for (int i = 0; i < 3; i++) step(256'h5, 256'h9, 1'b0, "hold");

        // Alternating pass/fail stream.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(256'h10, 256'h20, 1'b0, "alt_pass");
            else            step(256'h30, 256'h20, 1'b0, "alt_fail");
        end

        // Reset one cycle after a passing input: that pass must vanish.
        step(256'h2, 256'h8, 1'b0, "pre_rst_pass");
        step(256'h1, 256'h8, 1'b1, "mid_rst");
        step(256'hFF, 256'h8, 1'b0, "post_rst0");
        step(256'h4, 256'h8, 1'b0, "post_rst1");
        step(256'h4, 256'h8, 1'b0, "post_rst2");

        // Randomized operands biased toward slice-boundary cases.
        for (int i = 0; i < 10000; i++) begin
            mode = $urandom_range(0, 6);
            h    = rnd256();
            t    = rnd256();
            case (mode)
                1: t = h;
                2: begin
                    k = $urandom_range(0, 3);
                    t = h;
                    t[k*64 +: 64] = $urandom;
                    if ($urandom_range(0, 1) == 1) t[k*64 + 32 +: 32] = h[k*64 + 32 +: 32];
                end
                3: t = h ^ (one << $urandom_range(0, 255));
                4: h = '0;
                5: t = '0;
                6: begin
                    t = h;
                    t[63:0] = rnd256();
                end
                default: ;
            endcase
            r = ($urandom_range(0, 63) == 0);
            step(h, t, r, "random");
        end
        step(256'h0, 256'h0, 1'b0, "drain1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
